// File: rtl/pipelined_opcode_decoder_if.sv
// Fetch-side and execute-side handshake plus decoded control bundle of the opcode decoder stage.
interface pipelined_opcode_decoder_if;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        dec_valid;
   logic        dec_ready;
   logic        fpu_en;
   logic        mul_en;
   logic        branch;
   logic        mem_read;
   logic        mem_to_reg;
   logic        mem_write;
   logic        alu_src;
   logic        reg_write;
   logic [1:0]  jump;
   logic [1:0]  alu_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        illegal;
   logic        mdu_busy;
   logic        fpu_busy;

   modport master (
      output instr, instr_valid, dec_ready,
      input  instr_ready, dec_valid, fpu_en, mul_en, branch, mem_read, mem_to_reg,
             mem_write, alu_src, reg_write, jump, alu_op, rd, rs1, rs2, illegal,
             mdu_busy, fpu_busy
   );

   modport slave (
      input  instr, instr_valid, dec_ready,
      output instr_ready, dec_valid, fpu_en, mul_en, branch, mem_read, mem_to_reg,
             mem_write, alu_src, reg_write, jump, alu_op, rd, rs1, rs2, illegal,
             mdu_busy, fpu_busy
   );
endinterface

// File: rtl/pipelined_opcode_decoder.sv
// Registered RV32IMF decode stage with valid/ready on both sides and MDU/FPU issue blocking.
// Optional macro DEC_ILLEGAL_TRAP_EN reports unrecognised encodings on 'illegal'.
module pipelined_opcode_decoder #(
   parameter int MDU_LAT = 4,
   parameter int FPU_LAT = 6,
   parameter int CNT_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   pipelined_opcode_decoder_if.slave bus
);

   typedef struct packed {
      logic       fpu_en;
      logic       mul_en;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] jump;
      logic [1:0] alu_op;
      logic       fp_arith;
   } ctrl_t;

   ctrl_t            ctrl_d;
   ctrl_t            ctrl_q;
   logic             vld_q;
   logic             fire;
   logic             block;
   logic             capture;
   logic [CNT_W-1:0] mdu_cnt;
   logic [CNT_W-1:0] fpu_cnt;
   logic [4:0]       rd_q;
   logic [4:0]       rs1_q;
   logic [4:0]       rs2_q;
   logic [6:0]       opcode;
   logic [6:0]       funct7;
   logic [2:0]       unused_funct3;
`ifdef DEC_ILLEGAL_TRAP_EN
   logic             illegal_d;
   logic             illegal_q;
`endif

   assign opcode        = bus.instr[6:0];
   assign funct7        = bus.instr[31:25];
   assign unused_funct3 = bus.instr[14:12];

   always_comb begin
      ctrl_d = '0;
`ifdef DEC_ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
      case (opcode)
         7'b0110011: begin
            if (funct7 == 7'b0000001) begin
               ctrl_d.mul_en    = 1'b1;
               ctrl_d.reg_write = 1'b1;
            end
`ifdef DEC_ILLEGAL_TRAP_EN
            else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
               illegal_d = 1'b1;
            end
`endif
            else begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.alu_op    = 2'b10;
            end
         end
         7'b0010011: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = 2'b10;
         end
         7'b0000011, 7'b0000111: begin
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.fpu_en     = opcode[2];
         end
         7'b0100011, 7'b0100111: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.fpu_en    = opcode[2];
         end
         7'b1100011: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = 2'b01;
         end
         7'b1101111: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.jump      = 2'b10;
         end
         7'b1100111: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.jump      = 2'b01;
         end
         7'b0110111, 7'b0010111: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = 2'b11;
         end
         7'b1010011: begin
            ctrl_d.fpu_en    = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.fp_arith  = 1'b1;
         end
         default: begin
`ifdef DEC_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
`endif
         end
      endcase
   end

   // A held MDU/FP-arith op waits until the previous op of its class has left the unit.
   assign block   = (ctrl_q.mul_en && mdu_cnt != '0) || (ctrl_q.fp_arith && fpu_cnt != '0);
   assign fire    = bus.dec_valid && bus.dec_ready;
   assign capture = bus.instr_valid && bus.instr_ready && !flush;

   assign bus.dec_valid   = vld_q && !block;
   assign bus.instr_ready = !vld_q || fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         ctrl_q <= '0;
         rd_q   <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
      end else begin
         if (flush) begin
            vld_q <= 1'b0;
         end else if (capture) begin
            vld_q <= 1'b1;
         end else if (fire) begin
            vld_q <= 1'b0;
         end
         if (capture) begin
            ctrl_q <= ctrl_d;
            rd_q   <= bus.instr[11:7];
            rs1_q  <= bus.instr[19:15];
            rs2_q  <= bus.instr[24:20];
         end
      end
   end

   // Counters survive flush because the unit stays occupied by an already-issued op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdu_cnt <= '0;
         fpu_cnt <= '0;
      end else begin
         if (fire && ctrl_q.mul_en) begin
            mdu_cnt <= CNT_W'(MDU_LAT - 1);
         end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - CNT_W'(1);
         end
         if (fire && ctrl_q.fp_arith) begin
            fpu_cnt <= CNT_W'(FPU_LAT - 1);
         end else if (fpu_cnt != '0) begin
            fpu_cnt <= fpu_cnt - CNT_W'(1);
         end
      end
   end

`ifdef DEC_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else if (capture) begin
         illegal_q <= illegal_d;
      end
   end
   assign bus.illegal = illegal_q;
`else
   assign bus.illegal = 1'b0;
`endif

   assign bus.fpu_en     = ctrl_q.fpu_en;
   assign bus.mul_en     = ctrl_q.mul_en;
   assign bus.branch     = ctrl_q.branch;
   assign bus.mem_read   = ctrl_q.mem_read;
   assign bus.mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.mem_write  = ctrl_q.mem_write;
   assign bus.alu_src    = ctrl_q.alu_src;
   assign bus.reg_write  = ctrl_q.reg_write;
   assign bus.jump       = ctrl_q.jump;
   assign bus.alu_op     = ctrl_q.alu_op;
   assign bus.rd         = rd_q;
   assign bus.rs1        = rs1_q;
   assign bus.rs2        = rs2_q;
   assign bus.mdu_busy   = (mdu_cnt != '0);
   assign bus.fpu_busy   = (fpu_cnt != '0);

endmodule

// File: tb/tb_pipelined_opcode_decoder.sv
// Directed self-checking bench for pipelined_opcode_decoder at MDU_LAT=4, FPU_LAT=6.
module tb_pipelined_opcode_decoder;

   logic clk;
   logic rst_n;
   logic flush;
   int   n_checks;
   int   n_fail;

   pipelined_opcode_decoder_if bus ();

   pipelined_opcode_decoder #(
      .MDU_LAT (4),
      .FPU_LAT (6),
      .CNT_W   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag order: fpu_en mul_en branch mem_read mem_to_reg mem_write alu_src reg_write jump[1:0] alu_op[1:0]
   localparam logic [11:0] F_NONE = 12'b0000_0000_0000;
   localparam logic [11:0] F_ADDI = 12'b0000_0011_0010;
   localparam logic [11:0] F_LW   = 12'b0001_1011_0000;
   localparam logic [11:0] F_SW   = 12'b0000_0110_0000;
   localparam logic [11:0] F_BEQ  = 12'b0010_0000_0001;
   localparam logic [11:0] F_JAL  = 12'b0000_0001_1000;
   localparam logic [11:0] F_JALR = 12'b0000_0011_0100;
   localparam logic [11:0] F_MUL  = 12'b0100_0001_0000;
   localparam logic [11:0] F_FLW  = 12'b1001_1011_0000;

   localparam logic [31:0] I_ADDI = 32'h00A00093;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_MUL  = 32'h022081B3;
   localparam logic [31:0] I_FADD = 32'h002081D3;
   localparam logic [31:0] I_FLW  = 32'h0000A107;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   function automatic logic [11:0] flags();
      return {bus.fpu_en, bus.mul_en, bus.branch, bus.mem_read, bus.mem_to_reg,
              bus.mem_write, bus.alu_src, bus.reg_write, bus.jump, bus.alu_op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] word, input logic valid);
      bus.instr       = word;
      bus.instr_valid = valid;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] s_instr [5];
      logic [11:0] s_flags [5];
      logic [4:0]  s_rd    [5];
      logic [4:0]  s_rs1   [5];
      logic [4:0]  s_rs2   [5];

      s_instr = '{32'h0000A103, 32'h0020A023, 32'h00208463, 32'h008000EF, 32'h000080E7};
      s_flags = '{F_LW, F_SW, F_BEQ, F_JAL, F_JALR};
      s_rd    = '{5'd2, 5'd0, 5'd8, 5'd1, 5'd1};
      s_rs1   = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd1};
      s_rs2   = '{5'd0, 5'd2, 5'd2, 5'd8, 5'd0};

      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.dec_ready = 1'b1;
      applyStimulus(32'h0, 1'b0);

      tick();
      checkOutput("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
      checkOutput("reset_instr_ready", 32'(bus.instr_ready), 32'd1);
      rst_n = 1'b1;

      // Reset mid-stream while a jal is held
      applyStimulus(32'h008000EF, 1'b1);
      tick();
      checkOutput("pre_reset_valid", 32'(bus.dec_valid), 32'd1);
      applyStimulus(32'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_dec_valid", 32'(bus.dec_valid), 32'd0);
      checkOutput("midreset_instr_ready", 32'(bus.instr_ready), 32'd1);
      checkOutput("midreset_flags", 32'(flags()), 32'(F_NONE));
      checkOutput("midreset_regs", 32'({bus.rd, bus.rs1, bus.rs2}), 32'd0);
      checkOutput("midreset_misc", 32'({bus.illegal, bus.mdu_busy, bus.fpu_busy}), 32'd0);
      tick();
      rst_n = 1'b1;

      // addi: one cycle from accept to dec_valid
      applyStimulus(I_ADDI, 1'b1);
      tick();
      checkOutput("addi_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("addi_flags", 32'(flags()), 32'(F_ADDI));
      checkOutput("addi_rd_rs1", 32'({bus.rd, bus.rs1}), 32'({5'd1, 5'd0}));

      // Back-to-back stream, one bundle per cycle
      for (int i = 0; i < 5; i++) begin
         applyStimulus(s_instr[i], 1'b1);
         tick();
         checkOutput($sformatf("stream%0d_valid", i), 32'(bus.dec_valid), 32'd1);
         checkOutput($sformatf("stream%0d_ready", i), 32'(bus.instr_ready), 32'd1);
         checkOutput($sformatf("stream%0d_flags", i), 32'(flags()), 32'(s_flags[i]));
         checkOutput($sformatf("stream%0d_regs", i), 32'({bus.rd, bus.rs1, bus.rs2}),
                     32'({s_rd[i], s_rs1[i], s_rs2[i]}));
      end
      applyStimulus(32'h0, 1'b0);
      tick();
      checkOutput("stream_drain_valid", 32'(bus.dec_valid), 32'd0);

      // Two consecutive muls issue four cycles apart
      applyStimulus(I_MUL, 1'b1);
      tick();
      checkOutput("mul1_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("mul1_flags", 32'(flags()), 32'(F_MUL));
      checkOutput("mul1_regs", 32'({bus.rd, bus.rs1, bus.rs2}), 32'({5'd3, 5'd1, 5'd2}));
      checkOutput("mul1_busy", 32'(bus.mdu_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         applyStimulus(32'h0, 1'b0);
         checkOutput($sformatf("mul2_blocked%0d_valid", i), 32'(bus.dec_valid), 32'd0);
         checkOutput($sformatf("mul2_blocked%0d_busy", i), 32'(bus.mdu_busy), 32'd1);
         checkOutput($sformatf("mul2_blocked%0d_ready", i), 32'(bus.instr_ready), 32'd0);
         checkOutput($sformatf("mul2_blocked%0d_flags", i), 32'(flags()), 32'(F_MUL));
      end
      tick();
      checkOutput("mul2_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("mul2_busy", 32'(bus.mdu_busy), 32'd0);
      tick();
      checkOutput("mul2_fired_busy", 32'(bus.mdu_busy), 32'd1);
      checkOutput("mul2_fired_valid", 32'(bus.dec_valid), 32'd0);
      tick();
      tick();
      tick();
      checkOutput("mdu_idle", 32'(bus.mdu_busy), 32'd0);

      // fadd then flw: FP load is never blocked
      applyStimulus(I_FADD, 1'b1);
      tick();
      checkOutput("fadd_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("fadd_flags", 32'(flags()), 32'(12'b1000_0001_0000));
      applyStimulus(I_FLW, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("flw_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("flw_flags", 32'(flags()), 32'(F_FLW));
      checkOutput("flw_fpu_busy", 32'(bus.fpu_busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("fpu_busy%0d", i), 32'(bus.fpu_busy), 32'd1);
      end
      tick();
      checkOutput("fpu_idle", 32'(bus.fpu_busy), 32'd0);
      checkOutput("fpu_idle_valid", 32'(bus.dec_valid), 32'd0);

      // dec_ready low for three cycles, flush on the third
      bus.dec_ready = 1'b0;
      applyStimulus(I_ADDI, 1'b1);
      tick();
      applyStimulus(I_LW, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("hold%0d_valid", i), 32'(bus.dec_valid), 32'd1);
         checkOutput($sformatf("hold%0d_ready", i), 32'(bus.instr_ready), 32'd0);
         checkOutput($sformatf("hold%0d_flags", i), 32'(flags()), 32'(F_ADDI));
         checkOutput($sformatf("hold%0d_rd", i), 32'(bus.rd), 32'd1);
         if (i == 2) flush = 1'b1;
         tick();
      end
      flush = 1'b0;
      applyStimulus(32'h0, 1'b0);
      checkOutput("flush_valid", 32'(bus.dec_valid), 32'd0);
      checkOutput("flush_ready", 32'(bus.instr_ready), 32'd1);
      bus.dec_ready = 1'b1;
      tick();
      checkOutput("flush_no_capture", 32'(bus.dec_valid), 32'd0);

      // flush together with fire: the mul still issues and loads the counter
      applyStimulus(I_MUL, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flushfire_valid", 32'(bus.dec_valid), 32'd0);
      checkOutput("flushfire_busy", 32'(bus.mdu_busy), 32'd1);
      tick();
      tick();
      tick();
      checkOutput("flushfire_idle", 32'(bus.mdu_busy), 32'd0);

      // Unrecognised opcode
      applyStimulus(I_BAD, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0);
      checkOutput("bad_valid", 32'(bus.dec_valid), 32'd1);
      checkOutput("bad_flags", 32'(flags()), 32'(F_NONE));
`ifdef DEC_ILLEGAL_TRAP_EN
      checkOutput("bad_illegal", 32'(bus.illegal), 32'd1);
`else
      checkOutput("bad_illegal", 32'(bus.illegal), 32'd0);
`endif
      tick();
      checkOutput("bad_fired", 32'(bus.dec_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
